// File: rtl/alluvial_sequencer_if.sv
// Bundle of the sequencer's byte stream, ALU drive/sample and response signals.
// slave: the sequencer side; master: the environment (stream source, ALU, consumer).
interface alluvial_sequencer_if;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned OP_W   = 32;
  localparam int unsigned STAT_W = 2;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_result;
  logic              alu_error;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic [STAT_W-1:0] out_status;

  modport slave (
    input  in_valid, in_data, alu_result, alu_error, out_ready,
    output in_ready, alu_op, alu_a, alu_b, out_valid, out_result, out_status
  );

  modport master (
    output in_valid, in_data, alu_result, alu_error, out_ready,
    input  in_ready, alu_op, alu_a, alu_b, out_valid, out_result, out_status
  );
endinterface

// File: rtl/alluvial_sequencer.sv
// Byte-serial command front end for the alluvial ALU: op/A/B frame in, registered response out.
// Optional inter-byte idle timeout enabled by defining ALLUVIAL_SEQ_TIMEOUT_EN.
module alluvial_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic           clk,
  input logic           rst_n,
  alluvial_sequencer_if.slave bus
);
  localparam int unsigned DATA_W = 8;
  localparam int unsigned OP_W   = 32;
  localparam int unsigned CNT_W  = 16;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_ALU_ERR = 2'd1;
  localparam logic [1:0] ST_BAD_OP  = 2'd2;
  localparam logic [1:0] ST_TIMEOUT = 2'd3;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("alluvial_sequencer: TIMEOUT_CYCLES must be within 1..65535");
  end

  typedef enum logic [2:0] {
    GET_OP = 3'd0,
    GET_A  = 3'd1,
    GET_B  = 3'd2,
    EXEC   = 3'd3,
    RESP   = 3'd4
  } state_t;

  state_t state;
  logic   xfer;
  logic   timeout;

  // Ready is a pure state decode so it can never combinationally depend on in_valid.
  assign bus.in_ready = (state == GET_OP) || (state == GET_A) || (state == GET_B);
  assign xfer         = bus.in_valid && bus.in_ready;

`ifdef ALLUVIAL_SEQ_TIMEOUT_EN
  logic [CNT_W-1:0] idle_cnt;
  logic             waiting;

  assign waiting = (state == GET_A) || (state == GET_B);
  // Fires on the edge where the idle count would reach TIMEOUT_CYCLES.
  assign timeout = waiting && !xfer && (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (xfer || !waiting) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + CNT_W'(1);
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= GET_OP;
      bus.alu_op     <= '0;
      bus.alu_a      <= '0;
      bus.alu_b      <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_result <= '0;
      bus.out_status <= ST_OK;
    end else begin
      case (state)
        GET_OP: begin
          if (xfer) begin
            bus.alu_op <= {{(OP_W - DATA_W){1'b0}}, bus.in_data};
            state      <= GET_A;
          end
        end
        GET_A: begin
          if (xfer) begin
            bus.alu_a <= bus.in_data;
            state     <= GET_B;
          end else if (timeout) begin
            bus.out_valid  <= 1'b1;
            bus.out_result <= '0;
            bus.out_status <= ST_TIMEOUT;
            state          <= RESP;
          end
        end
        GET_B: begin
          if (xfer) begin
            bus.alu_b <= bus.in_data;
            state     <= EXEC;
          end else if (timeout) begin
            bus.out_valid  <= 1'b1;
            bus.out_result <= '0;
            bus.out_status <= ST_TIMEOUT;
            state          <= RESP;
          end
        end
        EXEC: begin
          // ALU outputs have settled from the registered operands by now.
          bus.out_valid <= 1'b1;
          if (bus.alu_op == '0) begin
            bus.out_result <= bus.alu_result;
            bus.out_status <= bus.alu_error ? ST_ALU_ERR : ST_OK;
          end else begin
            bus.out_result <= '0;
            bus.out_status <= ST_BAD_OP;
          end
          state <= RESP;
        end
        RESP: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state         <= GET_OP;
          end
        end
        default: begin
          state <= GET_OP;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alluvial_sequencer.sv
// Self-checking bench for alluvial_sequencer: directed frames, back-pressure, reset, random traffic.
// A behavioural ADD-only ALU stands in for the downstream alluvial block.
module tb_alluvial_sequencer;
  localparam int unsigned TMO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alluvial_sequencer_if bus ();

  alluvial_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Stand-in ALU: ADD for opcode 0, deliberately noisy outputs for anything else.
  always_comb begin
    if (bus.alu_op == 32'd0) begin
      {bus.alu_error, bus.alu_result} = 9'(bus.alu_a) + 9'(bus.alu_b);
    end else begin
      bus.alu_result = bus.alu_a ^ bus.alu_b ^ 8'h5a;
      bus.alu_error  = 1'b1;
    end
  end

  typedef struct { logic [7:0] d; int c; } acc_t;
  typedef struct { logic [7:0] r; logic [1:0] s; int c; } resp_t;
  acc_t  acc_q[$];
  resp_t resp_q[$];

  // Transfers observed mid-cycle; each one completes on the following rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.in_valid && bus.in_ready) acc_q.push_back('{bus.in_data, cyc});
      if (bus.out_valid && bus.out_ready) resp_q.push_back('{bus.out_result, bus.out_status, cyc});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // All stimulus tasks start and end at 1 time unit after a rising edge.
  task automatic send_byte(input logic [7:0] d);
    int n = 0;
    bit done = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (!done && n < 200) begin
      @(negedge clk);
      if (bus.in_ready) done = 1;
      @(posedge clk); #1;
      n++;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL send_byte: byte %02h not accepted after %0d cycles", d, n);
    end
  endtask

  task automatic get_resp(output logic [7:0] r, output logic [1:0] s, output int w, output bit ok);
    ok = 0; w = 0; r = 'x; s = 'x;
    while (!ok && w < 60) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        ok = 1; r = bus.out_result; s = bus.out_status;
      end else begin
        w++;
      end
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [9:0] ref_resp(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
    int sum;
    sum = int'(a) + int'(b);
    if (op != 8'h00) return {2'd2, 8'h00};
    return {(sum > 255) ? 2'd1 : 2'd0, 8'(sum)};
  endfunction

  task automatic test_reset;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.out_result, bus.out_status, bus.alu_op, bus.alu_a, bus.alu_b} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ov=%b r=%02h s=%0d op=%08h a=%02h b=%02h want all 0",
               bus.out_valid, bus.out_result, bus.out_status, bus.alu_op, bus.alu_a, bus.alu_b);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got in_ready=%b out_valid=%b want 1 0", bus.in_ready, bus.out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_directed;
    logic [7:0] ops[4] = '{8'h00, 8'h00, 8'h05, 8'h00};
    logic [7:0] as[4]  = '{8'h12, 8'hff, 8'haa, 8'h12};
    logic [7:0] bs[4]  = '{8'h34, 8'h01, 8'hbb, 8'h34};
    logic [7:0] er[4]  = '{8'h46, 8'h00, 8'h00, 8'h46};
    logic [1:0] es[4]  = '{2'd0, 2'd1, 2'd2, 2'd0};
    logic [7:0] r; logic [1:0] s; int w; bit ok;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_byte(ops[i]); send_byte(as[i]); send_byte(bs[i]);
      get_resp(r, s, w, ok);
      checks++;
      if (!ok || r !== er[i] || s !== es[i] || w != 1) begin
        errors++;
        $display("FAIL directed_%0d: got ok=%0d r=%02h s=%0d latency=%0d want r=%02h s=%0d latency=1",
                 i, ok, r, s, w, er[i], es[i]);
      end
      checks++;
      if (bus.alu_op !== {24'h0, ops[i]} || bus.alu_a !== as[i] || bus.alu_b !== bs[i]) begin
        errors++;
        $display("FAIL directed_alu_regs_%0d: got op=%08h a=%02h b=%02h want %08h %02h %02h",
                 i, bus.alu_op, bus.alu_a, bus.alu_b, {24'h0, ops[i]}, as[i], bs[i]);
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] r; logic [1:0] s; int w; bit ok;
    bus.out_ready = 1'b1;
    send_byte(8'h00); send_byte(8'h12);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({bus.out_valid, bus.out_result, bus.out_status, bus.alu_op, bus.alu_a, bus.alu_b} !== '0) begin
        errors++;
        $display("FAIL mid_reset_outputs_%0d: got ov=%b r=%02h s=%0d op=%08h a=%02h b=%02h want all 0",
                 i, bus.out_valid, bus.out_result, bus.out_status, bus.alu_op, bus.alu_a, bus.alu_b);
      end
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_ready: got in_ready=%b want 1", bus.in_ready);
    end
    @(posedge clk); #1;
    w = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) w++;
      @(posedge clk); #1;
    end
    checks++;
    if (w != 0) begin
      errors++;
      $display("FAIL partial_frame_resp: got out_valid high %0d cycles want 0", w);
    end
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h02);
    get_resp(r, s, w, ok);
    checks++;
    if (!ok || r !== 8'h03 || s !== 2'd0) begin
      errors++;
      $display("FAIL post_reset_frame: got ok=%0d r=%02h s=%0d want r=03 s=0", ok, r, s);
    end
  endtask

  task automatic test_backpressure;
    int w = 0;
    int bad = 0;
    bus.out_ready = 1'b0;
    send_byte(8'h00); send_byte(8'h80); send_byte(8'h80);
    while (w < 10) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) break;
      @(posedge clk); #1;
      w++;
    end
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_result !== 8'h00 || bus.out_status !== 2'd1 || bus.in_ready !== 1'b0) begin
        errors++; bad++;
        if (bad < 4)
          $display("FAIL stall_hold_%0d: got ov=%b r=%02h s=%0d in_ready=%b want 1 00 1 0",
                   i, bus.out_valid, bus.out_result, bus.out_status, bus.in_ready);
      end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: got out_valid=%b in_ready=%b want 0 1", bus.out_valid, bus.in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    logic [7:0] fr[9];
    logic [9:0] e;
    int n = 0;
    acc_q.delete(); resp_q.delete();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 9; i++) fr[i] = (i % 3 == 0) ? 8'h00 : 8'($urandom);
    for (int i = 0; i < 9; i++) send_byte(fr[i]);
    while (resp_q.size() < 3 && n < 20) begin @(posedge clk); #1; n++; end
    checks++;
    if (resp_q.size() != 3 || acc_q.size() != 9) begin
      errors++;
      $display("FAIL b2b_count: got resp=%0d bytes=%0d want 3 9", resp_q.size(), acc_q.size());
    end else begin
      for (int f = 0; f < 3; f++) begin
        e = ref_resp(fr[3*f], fr[3*f+1], fr[3*f+2]);
        checks++;
        if (resp_q[f].r !== e[7:0] || resp_q[f].s !== e[9:8] || resp_q[f].c - acc_q[3*f+2].c != 2) begin
          errors++;
          $display("FAIL b2b_resp_%0d: got r=%02h s=%0d lat=%0d want r=%02h s=%0d lat=2",
                   f, resp_q[f].r, resp_q[f].s, resp_q[f].c - acc_q[3*f+2].c, e[7:0], e[9:8]);
        end
        if (f > 0) begin
          checks++;
          if (acc_q[3*f].c - acc_q[3*f-3].c != 5) begin
            errors++;
            $display("FAIL b2b_period_%0d: got %0d cycles want 5", f, acc_q[3*f].c - acc_q[3*f-3].c);
          end
        end
      end
    end
  endtask

  task automatic test_random;
    localparam int NFR = 24;
    bit done = 0;
    int n = 0;
    int bad = 0;
    logic [9:0] e;
    acc_q.delete(); resp_q.delete();
    fork
      begin
        for (int f = 0; f < NFR; f++) begin
          for (int k = 0; k < 3; k++) begin
            logic [7:0] d;
            if (k == 0) d = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            else        d = 8'($urandom);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            send_byte(d);
          end
        end
        done = 1;
      end
      begin
        while (!done) begin
          bus.out_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    while (resp_q.size() < NFR && n < 30) begin @(posedge clk); #1; n++; end
    checks++;
    if (resp_q.size() != NFR || acc_q.size() != 3 * NFR) begin
      errors++;
      $display("FAIL random_count: got resp=%0d bytes=%0d want %0d %0d", resp_q.size(), acc_q.size(), NFR, 3 * NFR);
    end else begin
      for (int f = 0; f < NFR; f++) begin
        e = ref_resp(acc_q[3*f].d, acc_q[3*f+1].d, acc_q[3*f+2].d);
        checks++;
        if (resp_q[f].r !== e[7:0] || resp_q[f].s !== e[9:8]) begin
          errors++; bad++;
          if (bad < 5)
            $display("FAIL random_resp_%0d: frame %02h %02h %02h got r=%02h s=%0d want r=%02h s=%0d",
                     f, acc_q[3*f].d, acc_q[3*f+1].d, acc_q[3*f+2].d, resp_q[f].r, resp_q[f].s, e[7:0], e[9:8]);
        end
      end
    end
  endtask

`ifdef ALLUVIAL_SEQ_TIMEOUT_EN
  task automatic test_timeout;
    logic [7:0] r; logic [1:0] s; int w; bit ok;
    bus.out_ready = 1'b1;
    send_byte(8'h00); send_byte(8'h12);
    get_resp(r, s, w, ok);
    checks++;
    if (!ok || r !== 8'h00 || s !== 2'd3 || w != int'(TMO)) begin
      errors++;
      $display("FAIL timeout_resp: got ok=%0d r=%02h s=%0d idle=%0d want r=00 s=3 idle=%0d", ok, r, s, w, TMO);
    end
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h01);
    get_resp(r, s, w, ok);
    checks++;
    if (!ok || r !== 8'h02 || s !== 2'd0) begin
      errors++;
      $display("FAIL timeout_recover: got ok=%0d r=%02h s=%0d want r=02 s=0", ok, r, s);
    end
  endtask
`else
  task automatic test_no_timeout;
    logic [7:0] r; logic [1:0] s; int w; bit ok;
    int seen = 0;
    bus.out_ready = 1'b1;
    send_byte(8'h00); send_byte(8'h12);
    repeat (3 * TMO) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL no_timeout_wait: got %0d cycles with response or not ready want 0", seen);
    end
    send_byte(8'h34);
    get_resp(r, s, w, ok);
    checks++;
    if (!ok || r !== 8'h46 || s !== 2'd0) begin
      errors++;
      $display("FAIL no_timeout_resp: got ok=%0d r=%02h s=%0d want r=46 s=0", ok, r, s);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_reset_mid_frame();
    test_backpressure();
    test_back_to_back();
    test_random();
`ifdef ALLUVIAL_SEQ_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
